// File: rtl/sipo_receiver_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sipo_receiver_if: serial link observation and parallel result bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface sipo_receiver_if #(
  parameter int WIDTH = 12
);
  logic             SL;
  logic             serial_in;
  logic [WIDTH-1:0] parallel_out;
  logic             data_valid;
  logic             busy;
  logic             frame_err;

  modport master (
    output SL,
    output serial_in,
    input  parallel_out,
    input  data_valid,
    input  busy,
    input  frame_err
  );

  modport slave (
    input  SL,
    input  serial_in,
    output parallel_out,
    output data_valid,
    output busy,
    output frame_err
  );
endinterface
`default_nettype wire

// File: rtl/sipo_receiver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sipo_receiver: reassembles LSB-first PISO frames, flags completion and aborts
// Rev 1.0
// ----------------------------------------------------------------------------
module sipo_receiver #(
  parameter int WIDTH = 12,
  parameter int LEAD  = 1
) (
  input  wire logic        clk,
  input  wire logic        rst,
  sipo_receiver_if.slave   link
);
  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int LEAD_W = $clog2(LEAD + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ALIGN = 2'd2,
    SHIFT = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   shift_reg, shift_nxt;
  logic [WIDTH-1:0]   word, word_nxt;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [LEAD_W-1:0]  lead_cnt, lead_cnt_nxt;
  logic               valid, valid_nxt;
  logic               err, err_nxt;
  logic [WIDTH-1:0]   shifted;

  assign shifted = {link.serial_in, shift_reg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      word      <= '0;
      bit_cnt   <= '0;
      lead_cnt  <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      word      <= word_nxt;
      bit_cnt   <= bit_cnt_nxt;
      lead_cnt  <= lead_cnt_nxt;
      valid     <= valid_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift_reg;
    word_nxt     = word;
    bit_cnt_nxt  = bit_cnt;
    lead_cnt_nxt = lead_cnt;
    valid_nxt    = 1'b0;
    err_nxt      = 1'b0;

    case (state)
      IDLE: begin
        if (link.SL) state_nxt = ARMED;
      end

      // The first SL=0 edge after a load is already alignment cycle 1.
      ARMED: begin
        if (!link.SL) begin
          if (LEAD <= 1) begin
            state_nxt   = SHIFT;
            shift_nxt   = '0;
            bit_cnt_nxt = '0;
          end else begin
            state_nxt    = ALIGN;
            lead_cnt_nxt = LEAD_W'(1);
          end
        end
      end

      ALIGN: begin
        if (link.SL) begin
          state_nxt    = ARMED;
          err_nxt      = 1'b1;
          lead_cnt_nxt = '0;
        end else if (lead_cnt == LEAD_W'(LEAD - 1)) begin
          state_nxt    = SHIFT;
          shift_nxt    = '0;
          bit_cnt_nxt  = '0;
          lead_cnt_nxt = '0;
        end else begin
          lead_cnt_nxt = lead_cnt + LEAD_W'(1);
        end
      end

      // The last bit is still on the line during the next load, so SL=1 here completes.
      SHIFT: begin
        if (bit_cnt == CNT_W'(WIDTH - 1)) begin
          shift_nxt   = shifted;
          word_nxt    = shifted;
          valid_nxt   = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = link.SL ? ARMED : IDLE;
        end else if (link.SL) begin
          state_nxt   = ARMED;
          err_nxt     = 1'b1;
          shift_nxt   = '0;
          bit_cnt_nxt = '0;
        end else begin
          shift_nxt   = shifted;
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign link.parallel_out = word;
  assign link.data_valid   = valid;
  assign link.frame_err    = err;
  assign link.busy         = (state == ALIGN) || (state == SHIFT);
endmodule
`default_nettype wire

// File: tb/tb_sipo_receiver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sipo_receiver: directed frames against hand-computed words and timing
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_sipo_receiver;
  localparam int WIDTH = 12;

  logic clk;
  logic rst;
  int   test_cnt;
  int   fail_cnt;

  sipo_receiver_if #(.WIDTH(WIDTH)) link ();

  sipo_receiver #(.WIDTH(WIDTH), .LEAD(1)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (link.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive inputs, take one rising edge, return at the following falling edge.
  task automatic cycle(input logic sl, input logic sin);
    link.SL        = sl;
    link.serial_in = sin;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Optional load edge E0, alignment edge E1, bits at E2..E13.
  task automatic send_frame(input string tag, input logic [WIDTH-1:0] w,
                            input logic do_load, input logic last_sl);
    int busy_cnt;
    int early_dv;
    int ferr_seen;
    busy_cnt  = 0;
    early_dv  = 0;
    ferr_seen = 0;
    if (do_load) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    if (link.busy) busy_cnt++;
    if (link.data_valid) early_dv++;
    if (link.frame_err) ferr_seen++;
    for (int k = 0; k < WIDTH; k++) begin
      cycle((k == WIDTH - 1) ? last_sl : 1'b0, w[k]);
      if (link.busy) busy_cnt++;
      if (link.data_valid && k != WIDTH - 1) early_dv++;
      if (link.frame_err) ferr_seen++;
    end
    check({tag, " word"},      32'(link.parallel_out), 32'(w));
    check({tag, " valid"},     32'(link.data_valid),   32'd1);
    check({tag, " busy_cnt"},  32'(busy_cnt),          32'd12);
    check({tag, " early_dv"},  32'(early_dv),          32'd0);
    check({tag, " frame_err"}, 32'(ferr_seen),         32'd0);
  endtask

  initial begin
    int pout_bad;
    int dv_seen;
    int busy_seen;
    test_cnt       = 0;
    fail_cnt       = 0;
    rst            = 1'b1;
    link.SL        = 1'b0;
    link.serial_in = 1'b0;
    @(negedge clk);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("rst pout",  32'(link.parallel_out), 32'h0);
    check("rst valid", 32'(link.data_valid),   32'h0);
    check("rst busy",  32'(link.busy),         32'h0);
    check("rst ferr",  32'(link.frame_err),    32'h0);
    rst = 1'b0;

    // Idle robustness: SL held low, serial_in noise.
    pout_bad  = 0;
    dv_seen   = 0;
    busy_seen = 0;
    for (int i = 0; i < 50; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)));
      if (link.parallel_out != '0) pout_bad++;
      if (link.data_valid) dv_seen++;
      if (link.busy) busy_seen++;
    end
    check("idle pout",  32'(pout_bad),  32'd0);
    check("idle valid", 32'(dv_seen),   32'd0);
    check("idle busy",  32'(busy_seen), 32'd0);

    // Single frame, then the strobe must drop and the word hold.
    send_frame("single", 12'hA5C, 1'b1, 1'b0);
    check("single busy_end", 32'(link.busy), 32'd0);
    cycle(1'b0, 1'b1);
    check("single valid_drop", 32'(link.data_valid),   32'd0);
    check("single hold",       32'(link.parallel_out), 32'hA5C);

    // Back-to-back: second load coincides with the first frame's last bit.
    send_frame("b2b_a", 12'h001, 1'b1, 1'b1);
    send_frame("b2b_b", 12'h800, 1'b0, 1'b0);

    // Abort after 5 shifts; the aborting SL=1 edge loads 0x123.
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    check("abort ferr",  32'(link.frame_err),    32'd1);
    check("abort valid", 32'(link.data_valid),   32'd0);
    check("abort pout",  32'(link.parallel_out), 32'h800);
    check("abort busy",  32'(link.busy),         32'd0);
    send_frame("after_abort", 12'h123, 1'b0, 1'b0);

    // Reset after 7 shifts.
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1);
    rst = 1'b1;
    cycle(1'b0, 1'b1);
    check("midrst pout",  32'(link.parallel_out), 32'h0);
    check("midrst valid", 32'(link.data_valid),   32'h0);
    check("midrst busy",  32'(link.busy),         32'h0);
    check("midrst ferr",  32'(link.frame_err),    32'h0);
    rst = 1'b0;
    send_frame("after_rst", 12'h5A5, 1'b1, 1'b0);

    // Extended load: SL held 4 cycles, timing counted from the last one.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    check("ext armed_busy", 32'(link.busy), 32'd0);
    send_frame("ext", 12'h3C3, 1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check("ext valid_drop", 32'(link.data_valid),   32'd0);
    check("ext hold",       32'(link.parallel_out), 32'h3C3);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end
endmodule
`default_nettype wire
